fetch_unit: RTL and testbench

Instruction fetch stage of the CPU, directly upstream of the register file and decoder. It owns the program counter and reads one opcode per instruction from the memory bus, plus an optional CB-prefixed second opcode byte. Immediate operand bytes are streamed into the register file's data1/data2 pair through its 8-bit write port. When an instruction is complete, it is presented to the executor through a valid/ack handshake.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type, register-file destination
// constant and the opcode immediate-length table used by fetch_unit.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_OP     = 3'd0,
        FETCH_CB     = 3'd1,
        FETCH_IMM_LO = 3'd2,
        FETCH_IMM_HI = 3'd3,
        WAIT_ACK     = 3'd4
    } fetch_state_t;

    // Register-file destination that shifts a byte into the data1/data2 pair.
    localparam logic [3:0] REG_DST_DATA = 4'b1100;
    localparam logic [7:0] OP_CB_PREFIX = 8'hCB;

    function automatic logic [1:0] imm_len_of(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd0;
        case (op)
            8'h01, 8'h08, 8'h11, 8'h21, 8'h31, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
            8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
                len = 2'd2;
            8'h06, 8'h0E, 8'h10, 8'h16, 8'h18, 8'h1E, 8'h20, 8'h26, 8'h28,
            8'h2E, 8'h30, 8'h36, 8'h38, 8'h3E, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
            8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6, 8'hF8, 8'hFE:
                len = 2'd1;
            default:
                len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, fetches opcode (+ optional CB byte) and
// streams immediates into the register file. CB handling under FETCH_CB_PREFIX_EN.
//
// state        | meaning
// FETCH_OP     | read opcode byte at pc
// FETCH_CB     | read second opcode byte after a CB prefix
// FETCH_IMM_LO | write low immediate byte into the register file
// FETCH_IMM_HI | write high immediate byte into the register file
// WAIT_ACK     | instruction presented, waiting for the executor
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        reg_write,
    output logic [3:0]  reg_dst,
    output logic [7:0]  reg_wdata,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic [1:0]  imm_len,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic [15:0] pc,
    input  logic        pc_load,
    input  logic [15:0] pc_wdata
);

    fetch_state_t state_q;
    logic [15:0]  pc_q;
    logic [7:0]   opcode_q;
    logic [1:0]   imm_len_q;
    logic         valid_q;
`ifdef FETCH_CB_PREFIX_EN
    logic         cb_prefix_q;
`endif

    logic [15:0]  pc_inc_d;
    logic [1:0]   op_len_d;
    logic         active_d;

    always_comb begin
        pc_inc_d = pc_q + 16'd1;
        op_len_d = imm_len_of(mem_rdata);
`ifndef FETCH_CB_PREFIX_EN
        // Without prefix support, CB carries a single immediate byte.
        if (mem_rdata == OP_CB_PREFIX) begin
            op_len_d = 2'd1;
        end
`endif
        // A redirect suppresses any bus or register-file activity this cycle.
        active_d  = cpu_en && !pc_load && !reset;
        mem_rd    = active_d && (state_q != WAIT_ACK);
        reg_write = active_d && ((state_q == FETCH_IMM_LO) || (state_q == FETCH_IMM_HI));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            opcode_q  <= 8'h00;
            imm_len_q <= 2'd0;
            valid_q   <= 1'b0;
`ifdef FETCH_CB_PREFIX_EN
            cb_prefix_q <= 1'b0;
`endif
        end else if (cpu_en) begin
            if (pc_load) begin
                pc_q    <= pc_wdata;
                state_q <= FETCH_OP;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    FETCH_OP: begin
                        opcode_q <= mem_rdata;
                        pc_q     <= pc_inc_d;
`ifdef FETCH_CB_PREFIX_EN
                        cb_prefix_q <= 1'b0;
                        if (mem_rdata == OP_CB_PREFIX) begin
                            imm_len_q <= 2'd0;
                            state_q   <= FETCH_CB;
                        end else
`endif
                        begin
                            imm_len_q <= op_len_d;
                            if (op_len_d == 2'd0) begin
                                state_q <= WAIT_ACK;
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= FETCH_IMM_LO;
                            end
                        end
                    end
`ifdef FETCH_CB_PREFIX_EN
                    FETCH_CB: begin
                        opcode_q    <= mem_rdata;
                        cb_prefix_q <= 1'b1;
                        imm_len_q   <= 2'd0;
                        pc_q        <= pc_inc_d;
                        state_q     <= WAIT_ACK;
                        valid_q     <= 1'b1;
                    end
`endif
                    FETCH_IMM_LO: begin
                        pc_q <= pc_inc_d;
                        if (imm_len_q == 2'd2) begin
                            state_q <= FETCH_IMM_HI;
                        end else begin
                            state_q <= WAIT_ACK;
                            valid_q <= 1'b1;
                        end
                    end
                    FETCH_IMM_HI: begin
                        pc_q    <= pc_inc_d;
                        state_q <= WAIT_ACK;
                        valid_q <= 1'b1;
                    end
                    WAIT_ACK: begin
                        if (instr_ack) begin
                            state_q <= FETCH_OP;
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= FETCH_OP;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign reg_dst     = REG_DST_DATA;
    assign reg_wdata   = mem_rdata;
    assign opcode      = opcode_q;
    assign imm_len     = imm_len_q;
    assign instr_valid = valid_q;
`ifdef FETCH_CB_PREFIX_EN
    assign cb_prefix   = cb_prefix_q;
`else
    assign cb_prefix   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, register-file shift model,
// and scoreboards for expected register writes and presented instructions.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        cpu_en;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        reg_write;
    logic [3:0]  reg_dst;
    logic [7:0]  reg_wdata;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic [1:0]  imm_len;
    logic        instr_valid;
    logic        instr_ack;
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_wdata;

    typedef struct {
        logic [7:0] op;
        logic       cb;
        logic [1:0] len;
    } instr_t;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_wr[$];
    instr_t     exp_instr[$];
    logic [7:0] rf_data1, rf_data2;
    logic       prev_valid;
    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .reg_write(reg_write), .reg_dst(reg_dst), .reg_wdata(reg_wdata),
        .opcode(opcode), .cb_prefix(cb_prefix), .imm_len(imm_len),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .pc(pc),
        .pc_load(pc_load), .pc_wdata(pc_wdata)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitor: register writes and newly presented instructions.
    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL reg_write_unexpected: got wdata %h, required no write", reg_wdata);
            end else begin
                logic [7:0] w;
                w = exp_wr.pop_front();
                if (reg_wdata !== w || reg_dst !== 4'hC) begin
                    errors++;
                    $display("FAIL reg_write_data: got %h dst %h, required %h dst c", reg_wdata, reg_dst, w);
                end
            end
            rf_data2 <= rf_data1;
            rf_data1 <= reg_wdata;
        end
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (exp_instr.size() == 0) begin
                errors++;
                $display("FAIL instr_unexpected: got opcode %h", opcode);
            end else begin
                instr_t e;
                e = exp_instr.pop_front();
                if (opcode !== e.op || cb_prefix !== e.cb || imm_len !== e.len) begin
                    errors++;
                    $display("FAIL instr_fields: got op %h cb %b len %0d, required op %h cb %b len %0d",
                             opcode, cb_prefix, imm_len, e.op, e.cb, e.len);
                end
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] addr);
        cpu_en = 1'b1; pc_load = 1'b1; pc_wdata = addr;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL jump_quiet: got mem_rd %b reg_write %b, required 0 0", mem_rd, reg_write);
        end
        cyc();
        pc_load = 1'b0; cpu_en = 1'b0;
        checks++;
        if (pc !== addr || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_pc: got pc %h valid %b, required %h 0", pc, instr_valid, addr);
        end
    endtask

    task automatic ack_it();
        cpu_en = 1'b1; instr_ack = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL wait_ack_mem_rd: got %b, required 0", mem_rd);
        end
        cyc();
        instr_ack = 1'b0; cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_drop_valid: got %b, required 0", instr_valid);
        end
    endtask

    task automatic test_reset();
        mem[16'h0000] = 8'h00;
        reset = 1'b1; cpu_en = 1'b1;
        cyc(); cyc();
        checks++;
        if (pc !== 16'h0000 || opcode !== 8'h00 || cb_prefix !== 1'b0 || imm_len !== 2'd0 ||
            instr_valid !== 1'b0 || mem_rd !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got pc %h op %h cb %b len %0d valid %b rd %b wr %b, required 0000 00 0 0 0 0 0",
                     pc, opcode, cb_prefix, imm_len, instr_valid, mem_rd, reg_write);
        end
        exp_instr.push_back('{op: 8'h00, cb: 1'b0, len: 2'd0});
        reset = 1'b0;
        cyc();
        cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || opcode !== 8'h00 || imm_len !== 2'd0 || pc !== 16'h0001) begin
            errors++;
            $display("FAIL plain_fetch: got valid %b op %h len %0d pc %h, required 1 00 0 0001",
                     instr_valid, opcode, imm_len, pc);
        end
        ack_it();
    endtask

    task automatic test_imm16();
        mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
        jump(16'h0010);
        exp_wr.push_back(8'h34); exp_wr.push_back(8'h12);
        exp_instr.push_back('{op: 8'h01, cb: 1'b0, len: 2'd2});
        cpu_en = 1'b1;
        cyc();
        checks++;
        if (reg_write !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL imm16_cycle2: got reg_write %b valid %b, required 1 0", reg_write, instr_valid);
        end
        cyc();
        cyc();
        cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 16'h0013) begin
            errors++;
            $display("FAIL imm16_done: got valid %b pc %h, required 1 0013", instr_valid, pc);
        end
        checks++;
        if (rf_data1 !== 8'h12 || rf_data2 !== 8'h34) begin
            errors++;
            $display("FAIL imm16_regfile: got data1 %h data2 %h, required 12 34", rf_data1, rf_data2);
        end
        ack_it();
    endtask

    task automatic test_cb();
        mem[16'h0020] = 8'hCB; mem[16'h0021] = 8'h37;
        jump(16'h0020);
`ifdef FETCH_CB_PREFIX_EN
        exp_instr.push_back('{op: 8'h37, cb: 1'b1, len: 2'd0});
`else
        exp_wr.push_back(8'h37);
        exp_instr.push_back('{op: 8'hCB, cb: 1'b0, len: 2'd1});
`endif
        cpu_en = 1'b1;
        cyc();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL cb_early_valid: got %b, required 0", instr_valid);
        end
        cyc();
        cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 16'h0022) begin
            errors++;
            $display("FAIL cb_done: got valid %b pc %h, required 1 0022", instr_valid, pc);
        end
        ack_it();
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h55;
        jump(16'hFFFF);
        exp_wr.push_back(8'h55);
        exp_instr.push_back('{op: 8'h3E, cb: 1'b0, len: 2'd1});
        cpu_en = 1'b1;
        cyc(); cyc();
        cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 16'h0001 || imm_len !== 2'd1) begin
            errors++;
            $display("FAIL wrap: got valid %b pc %h len %0d, required 1 0001 1", instr_valid, pc, imm_len);
        end
        ack_it();
    endtask

    task automatic test_pc_load_imm();
        mem[16'h0030] = 8'h21; mem[16'h0031] = 8'hAA; mem[16'h0100] = 8'h00;
        jump(16'h0030);
        cpu_en = 1'b1;
        cyc();
        pc_load = 1'b1; pc_wdata = 16'h0100;
        #1;
        checks++;
        if (reg_write !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL redirect_quiet: got reg_write %b mem_rd %b, required 0 0", reg_write, mem_rd);
        end
        cyc();
        pc_load = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 16'h0100 || mem_rd !== 1'b1 || reg_write !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_target: got addr %h rd %b wr %b valid %b, required 0100 1 0 0",
                     mem_addr, mem_rd, reg_write, instr_valid);
        end
        exp_instr.push_back('{op: 8'h00, cb: 1'b0, len: 2'd0});
        cyc();
        cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 16'h0101) begin
            errors++;
            $display("FAIL redirect_fetch: got valid %b pc %h, required 1 0101", instr_valid, pc);
        end
        ack_it();
    endtask

    task automatic test_stall();
        mem[16'h0040] = 8'hC3; mem[16'h0041] = 8'h78; mem[16'h0042] = 8'h56;
        jump(16'h0040);
        exp_wr.push_back(8'h78); exp_wr.push_back(8'h56);
        exp_instr.push_back('{op: 8'hC3, cb: 1'b0, len: 2'd2});
        cpu_en = 1'b1;
        cyc(); cyc();
        cpu_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (pc !== 16'h0042 || mem_rd !== 1'b0 || reg_write !== 1'b0 ||
                instr_valid !== 1'b0 || opcode !== 8'hC3 || imm_len !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold: got pc %h rd %b wr %b valid %b op %h len %0d, required 0042 0 0 0 c3 2",
                         pc, mem_rd, reg_write, instr_valid, opcode, imm_len);
            end
        end
        cpu_en = 1'b1;
        #1;
        checks++;
        if (reg_write !== 1'b1 || reg_wdata !== 8'h56) begin
            errors++;
            $display("FAIL stall_resume: got wr %b wdata %h, required 1 56", reg_write, reg_wdata);
        end
        cyc();
        cpu_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 16'h0043 || rf_data1 !== 8'h56 || rf_data2 !== 8'h78) begin
            errors++;
            $display("FAIL stall_done: got valid %b pc %h data1 %h data2 %h, required 1 0043 56 78",
                     instr_valid, pc, rf_data1, rf_data2);
        end
        ack_it();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ops  [6];
        logic [1:0]  lens [6];
        logic [7:0]  imms [6];
        logic [15:0] a;
        int          j, n;
        ops  = '{8'h00, 8'h06, 8'hCD, 8'hE0, 8'h76, 8'hFA};
        lens = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2};
        imms = '{8'h11, 8'h00, 8'h80, 8'h12, 8'h34, 8'h12};
        a = 16'h0200; j = 0;
        for (int i = 0; i < 6; i++) begin
            mem[a] = ops[i]; a = a + 16'd1;
            for (int k = 0; k < int'(lens[i]); k++) begin
                mem[a] = imms[j]; a = a + 16'd1; j++;
            end
        end
        jump(16'h0200);
        j = 0;
        for (int i = 0; i < 6; i++) begin
            exp_instr.push_back('{op: ops[i], cb: 1'b0, len: lens[i]});
            for (int k = 0; k < int'(lens[i]); k++) begin
                exp_wr.push_back(imms[j]); j++;
            end
            cpu_en = 1'b1;
            n = 0;
            while (instr_valid !== 1'b1 && n < 10) begin
                cyc();
                n++;
            end
            cpu_en = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || n != int'(lens[i]) + 1) begin
                errors++;
                $display("FAIL b2b_latency: op %h got valid %b after %0d cycles, required valid after %0d",
                         ops[i], instr_valid, n, int'(lens[i]) + 1);
            end
            ack_it();
        end
        checks++;
        if (pc !== 16'h020C) begin
            errors++;
            $display("FAIL b2b_pc: got %h, required 020c", pc);
        end
    endtask

    task automatic test_reset_mid();
        mem[16'h0050] = 8'h11; mem[16'h0051] = 8'h22; mem[16'h0052] = 8'h33;
        jump(16'h0050);
        cpu_en = 1'b1;
        cyc();
        cpu_en = 1'b0; reset = 1'b1;
        cyc();
        checks++;
        if (pc !== 16'h0000 || opcode !== 8'h00 || imm_len !== 2'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got pc %h op %h len %0d valid %b, required 0000 00 0 0",
                     pc, opcode, imm_len, instr_valid);
        end
        reset = 1'b0; cpu_en = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: got rd %b wr %b, required 1 0", mem_rd, reg_write);
        end
        cpu_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1; cpu_en = 1'b0; instr_ack = 1'b0; pc_load = 1'b0; pc_wdata = 16'h0000;
        rf_data1 = 8'h00; rf_data2 = 8'h00; prev_valid = 1'b0;
        test_reset();
        test_imm16();
        test_cb();
        test_wrap();
        test_pc_load_imm();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        cyc();
        checks++;
        if (exp_wr.size() != 0 || exp_instr.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d writes %0d instrs pending, required 0 0",
                     exp_wr.size(), exp_instr.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
